shr_seq: RTL and testbench



---
 rtl/shr_seq_if.sv | 31 +++
 rtl/shr_seq.sv | 95 +++++++++
 tb/tb_shr_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shr_seq_if.sv
// Handshake and data bundle for the sequential right shifter.
// The master drives the request side; the slave (shr_seq) drives status and result.
interface shr_seq_if;
    logic        i_start;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [1:0]  i_mode;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    modport master (
        output i_start,
        output i_a,
        output i_b,
        output i_mode,
        input  o_busy,
        input  o_done,
        input  o_result
    );

    modport slave (
        input  i_start,
        input  i_a,
        input  i_b,
        input  i_mode,
        output o_busy,
        output o_done,
        output o_result
    );
endinterface

// File: rtl/shr_seq.sv
// Sequential right shifter for the Mini-SRC ALU: shr, shra and ror, one bit per clock.
// The start/busy/done handshake lets the control unit stall while a shift is running.
module shr_seq (
    input  logic       clock,
    input  logic       reset_n,
    shr_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SHRA = 2'b01;
    localparam logic [1:0] MODE_ROR  = 2'b10;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_count;
    logic [1:0]  r_mode;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_b_large;
    logic [5:0]  w_count_init;
    logic        w_fill;

    // A new request is only taken when no shift is in flight; starts during SHIFT are dropped.
    assign w_accept  = bus.i_start && (r_state != S_SHIFT);
    assign w_b_large = (bus.i_b[31:5] != 27'd0);

    always_comb begin
        w_count_init = {1'b0, bus.i_b[4:0]};
        if (bus.i_mode != MODE_ROR && w_b_large) begin
            w_count_init = 6'd32;
        end
    end

    always_comb begin
        case (r_mode)
            MODE_SHRA: w_fill = r_result[31];
            MODE_ROR:  w_fill = r_result[0];
            default:   w_fill = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next_state = (w_count_init != 6'd0) ? S_SHIFT : S_DONE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_count == 6'd1) begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Result is loaded on acceptance and only moves during SHIFT; it is held otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= 6'd0;
            r_mode   <= 2'b00;
            r_result <= 32'h0000_0000;
        end else if (w_accept) begin
            r_count  <= w_count_init;
            r_mode   <= bus.i_mode;
            r_result <= bus.i_a;
        end else if (r_state == S_SHIFT) begin
            r_count  <= r_count - 6'd1;
            r_result <= {w_fill, r_result[31:1]};
        end
    end

    assign bus.o_busy   = (r_state == S_SHIFT);
    assign bus.o_done   = (r_state == S_DONE);
    assign bus.o_result = r_result;

endmodule

// File: tb/tb_shr_seq.sv
// Self-checking bench for shr_seq: directed plan cases, random operations against a
// shift-arithmetic reference model, mid-shift start, back-to-back and async reset.
module tb_shr_seq;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    shr_seq_if bus ();

    shr_seq u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: effective count from the mode rules, then a wide shift of the operand.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] m, output logic [31:0] r, output int n);
        logic [63:0] t;
        if (m == 2'b10) begin
            n = int'(b % 32);
            t = {a, a} >> n;
        end else begin
            n = (b >= 32) ? 32 : int'(b);
            t = (m == 2'b01) ? {{32{a[31]}}, a} : {32'h0, a};
            t = t >> n;
        end
        r = t[31:0];
    endfunction

    // Drives a one-cycle start, scrambles the inputs afterwards and measures the response.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                          output int lat, output logic [31:0] res,
                          output int busy_cnt, output int overlap);
        int c;
        bus.i_start = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_mode  = m;
        @(negedge clock);
        bus.i_start = 1'b0;
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
        bus.i_mode  = 2'($urandom_range(0, 3));
        c        = 1;
        busy_cnt = 0;
        overlap  = 0;
        while (!bus.o_done && c <= 40) begin
            if (bus.o_busy) busy_cnt++;
            @(negedge clock);
            c++;
        end
        if (bus.o_busy && bus.o_done) overlap++;
        lat = bus.o_done ? c : -1;
        res = bus.o_result;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] m);
        int          lat, bc, ov, n;
        logic [31:0] res, exp_r;
        model(a, b, m, exp_r, n);
        run_op(a, b, m, lat, res, bc, ov);
        total++;
        if (lat !== n + 1) begin
            bad++;
            $display("[TB] FAIL %s latency: got %0d want %0d", name, lat, n + 1);
        end
        total++;
        if (res !== exp_r) begin
            bad++;
            $display("[TB] FAIL %s result: got %h want %h (a=%h b=%h m=%0d)", name, res, exp_r, a, b, m);
        end
        total++;
        if (bc !== n || ov !== 0) begin
            bad++;
            $display("[TB] FAIL %s busy: got cycles=%0d overlap=%0d want cycles=%0d overlap=0", name, bc, ov, n);
        end
        @(negedge clock);
        total++;
        if (bus.o_done !== 1'b0 || bus.o_result !== exp_r) begin
            bad++;
            $display("[TB] FAIL %s hold: got done=%b result=%h want done=0 result=%h", name, bus.o_done, bus.o_result, exp_r);
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.i_start = 1'b0;
        bus.i_a     = 32'h0;
        bus.i_b     = 32'h0;
        bus.i_mode  = 2'b00;
        repeat (2) @(negedge clock);
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset: got busy=%b done=%b result=%h want 0 0 00000000", bus.o_busy, bus.o_done, bus.o_result);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        check_op("shr4",      32'h8000_0000, 32'd4,          2'b00);
        check_op("shra_neg",  32'hF000_0000, 32'd8,          2'b01);
        check_op("shra_pos",  32'h7000_0000, 32'd8,          2'b01);
        check_op("ror33",     32'h0000_0001, 32'd33,         2'b10);
        check_op("ror32",     32'h0000_0001, 32'd32,         2'b10);
        check_op("ror64",     32'hDEAD_BEEF, 32'd64,         2'b10);
        check_op("shr0",      32'h1234_5678, 32'd0,          2'b00);
        check_op("shr_max",   32'hFFFF_FFFF, 32'hFFFF_FFFF,  2'b00);
        check_op("shra100",   32'h8000_0000, 32'd100,        2'b01);
        check_op("shra32pos", 32'h7FFF_FFFF, 32'd32,         2'b01);
        check_op("mode11",    32'hC000_0003, 32'd31,         2'b11);
        check_op("shr_hi_b",  32'hFFFF_FFFF, 32'h0000_0100,  2'b00);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [1:0]  m;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            m = 2'($urandom_range(0, 3));
            check_op("random", a, b, m);
        end
    endtask

    task automatic test_mid_start();
        int          c;
        logic [31:0] exp_r;
        int          n;
        model(32'h8000_0000, 32'd10, 2'b01, exp_r, n);
        bus.i_start = 1'b1;
        bus.i_a     = 32'h8000_0000;
        bus.i_b     = 32'd10;
        bus.i_mode  = 2'b01;
        @(negedge clock);
        bus.i_start = 1'b0;
        c = 1;
        repeat (3) begin
            @(negedge clock);
            c++;
        end
        bus.i_start = 1'b1;
        bus.i_a     = 32'h0000_FFFF;
        bus.i_b     = 32'd2;
        bus.i_mode  = 2'b00;
        @(negedge clock);
        c++;
        bus.i_start = 1'b0;
        while (!bus.o_done && c <= 40) begin
            @(negedge clock);
            c++;
        end
        total++;
        if (c !== n + 1 || bus.o_result !== exp_r) begin
            bad++;
            $display("[TB] FAIL mid_start: got lat=%0d result=%h want lat=%0d result=%h", c, bus.o_result, n + 1, exp_r);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [31:0] as [3] = '{32'hA5A5_0000, 32'h8000_0001, 32'h0F0F_0F0F};
        logic [31:0] bs [3] = '{32'd3, 32'd0, 32'd5};
        logic [1:0]  ms [3] = '{2'b00, 2'b01, 2'b10};
        logic [31:0] exp_r;
        int          n, c;
        bus.i_start = 1'b1;
        bus.i_a     = as[0];
        bus.i_b     = bs[0];
        bus.i_mode  = ms[0];
        for (int i = 0; i < 3; i++) begin
            model(as[i], bs[i], ms[i], exp_r, n);
            @(negedge clock);
            c = 1;
            while (!bus.o_done && c <= 40) begin
                @(negedge clock);
                c++;
            end
            total++;
            if (c !== n + 1 || bus.o_result !== exp_r) begin
                bad++;
                $display("[TB] FAIL back_to_back[%0d]: got lat=%0d result=%h want lat=%0d result=%h", i, c, bus.o_result, n + 1, exp_r);
            end
            if (i < 2) begin
                bus.i_a    = as[i + 1];
                bus.i_b    = bs[i + 1];
                bus.i_mode = ms[i + 1];
            end
        end
        bus.i_start = 1'b0;
        @(negedge clock);
        total++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL back_to_back_idle: got busy=%b done=%b want 0 0", bus.o_busy, bus.o_done);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        bus.i_start = 1'b1;
        bus.i_a     = 32'hFFFF_0000;
        bus.i_b     = 32'd20;
        bus.i_mode  = 2'b01;
        @(negedge clock);
        bus.i_start = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got busy=%b done=%b result=%h want 0 0 00000000", bus.o_busy, bus.o_done, bus.o_result);
        end
        @(negedge clock);
        reset_n   = 1'b1;
        seen_done = 0;
        repeat (25) begin
            @(negedge clock);
            if (bus.o_done || bus.o_busy) seen_done++;
        end
        total++;
        if (seen_done !== 0) begin
            bad++;
            $display("[TB] FAIL reset_mid_quiet: got active cycles=%0d want 0", seen_done);
        end
        check_op("after_reset", 32'h8765_4321, 32'd7, 2'b10);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_mid_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
